// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: access width type, LSU FSM states and word masking shared by the LSU files
package memory_access_width;
   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_access_width_t;
endpackage

package load_store_unit_pkg;
   import memory_access_width::*;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} lsu_state_t;
   function automatic logic [31:0] width_mask(input memory_access_width_t w);
      return w == BYTE ? 32'h0000_00FF : w == HALF ? 32'h0000_FFFF : WORD_MASK;
   endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and memory bus of the LSU
interface load_store_unit_if;
   logic                                      req_valid;
   logic                                      req_ready;
   logic                                      req_write;
   logic [31:0]                               req_addr;
   logic [31:0]                               req_wdata;
   memory_access_width::memory_access_width_t req_width;
   logic                                      resp_valid;
   logic                                      resp_ready;
   logic [31:0]                               resp_rdata;
   logic                                      resp_misaligned;
   logic                                      mem_req;
   logic                                      mem_gnt;
   logic [31:0]                               mem_addr;
   logic                                      mem_we;
   logic [3:0]                                mem_be;
   logic [31:0]                               mem_wdata;
   logic                                      mem_rvalid;
   logic [31:0]                               mem_rdata;
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_width, resp_ready,
             mem_gnt, mem_rvalid, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_misaligned,
             mem_req, mem_addr, mem_we, mem_be, mem_wdata
   );
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_width, resp_ready,
             mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_misaligned,
             mem_req, mem_addr, mem_we, mem_be, mem_wdata
   );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: byte enables, store lane replication, misalign detect and load shift/mask
module lsu_lane_align
   import memory_access_width::*;
   import load_store_unit_pkg::*;
(
   input  logic [1:0]           offset,
   input  memory_access_width_t width,
   input  logic [31:0]          wdata,
   input  logic [1:0]           rd_offset,
   input  memory_access_width_t rd_width,
   input  logic [31:0]          mem_rdata,
   output logic [3:0]           be,
   output logic [31:0]          wdata_rep,
   output logic [31:0]          rdata,
   output logic                 misaligned
);
   always_comb begin
      be         = width == BYTE ? 4'b0001 << offset : width == HALF ? 4'b0011 << offset : 4'b1111;
      wdata_rep  = width == BYTE ? {4{wdata[7:0]}} : width == HALF ? {2{wdata[15:0]}} : wdata;
      misaligned = (width == HALF && offset[0]) || (width == WORD && offset != 2'b00);
      rdata      = (mem_rdata >> {rd_offset, 3'b000}) & width_mask(rd_width);
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit bridging core requests to a word-wide memory bus
module load_store_unit
   import memory_access_width::*;
   import load_store_unit_pkg::*;
(
   input logic               clk,
   input logic               rst_n,
   load_store_unit_if.slave  bus
);
   lsu_state_t           state_q, state_d;
   logic                 ready_q, ready_d;
   logic [31:0]          mem_addr_q, mem_addr_d;
   logic [31:0]          mem_wdata_q, mem_wdata_d;
   logic [3:0]           mem_be_q, mem_be_d;
   logic                 mem_we_q, mem_we_d;
   logic [1:0]           offset_q, offset_d;
   memory_access_width_t width_q, width_d;
   logic [31:0]          resp_rdata_q, resp_rdata_d;
   logic                 resp_mis_q, resp_mis_d;
   logic [3:0]           be;
   logic [31:0]          wdata_rep, rdata_al;
   logic                 misaligned, accept, capture;

   lsu_lane_align u_align (
      .offset    (bus.req_addr[1:0]),
      .width     (bus.req_width),
      .wdata     (bus.req_wdata),
      .rd_offset (offset_q),
      .rd_width  (width_q),
      .mem_rdata (bus.mem_rdata),
      .be        (be),
      .wdata_rep (wdata_rep),
      .rdata     (rdata_al),
      .misaligned(misaligned)
   );

   // ready_q keeps req_ready low while reset is held and for no longer than one edge after
   assign bus.req_ready       = state_q == IDLE && ready_q;
   assign bus.mem_req         = state_q == ADDR;
   assign bus.resp_valid      = state_q == RESP;
   assign bus.mem_addr        = mem_addr_q;
   assign bus.mem_wdata       = mem_wdata_q;
   assign bus.mem_be          = mem_be_q;
   assign bus.mem_we          = mem_we_q;
   assign bus.resp_rdata      = resp_rdata_q;
   assign bus.resp_misaligned = resp_mis_q;

   always_comb begin
      accept       = bus.req_valid && bus.req_ready;
      capture      = (state_q == ADDR && bus.mem_gnt && bus.mem_rvalid) ||
                     (state_q == DATA && bus.mem_rvalid);
      state_d      = state_q;
      ready_d      = 1'b1;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      mem_we_d     = mem_we_q;
      offset_d     = offset_q;
      width_d      = width_q;
      resp_rdata_d = resp_rdata_q;
      resp_mis_d   = resp_mis_q;
      case (state_q)
         IDLE:    state_d = accept ? (misaligned ? RESP : ADDR) : IDLE;
         ADDR:    state_d = bus.mem_gnt ? (bus.mem_rvalid ? RESP : DATA) : ADDR;
         DATA:    state_d = bus.mem_rvalid ? RESP : DATA;
         RESP:    state_d = bus.resp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
      if (accept && !misaligned) begin
         mem_addr_d  = {bus.req_addr[31:2], 2'b00};
         mem_wdata_d = wdata_rep;
         mem_be_d    = be;
         mem_we_d    = bus.req_write;
         offset_d    = bus.req_addr[1:0];
         width_d     = bus.req_width;
      end
      if (accept) begin
         resp_rdata_d = 32'h0;
         resp_mis_d   = misaligned;
      end
      if (capture) resp_rdata_d = mem_we_q ? 32'h0 : rdata_al;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ready_q      <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_be_q     <= 4'h0;
         mem_we_q     <= 1'b0;
         offset_q     <= 2'b00;
         width_q      <= BYTE;
         resp_rdata_q <= 32'h0;
         resp_mis_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         mem_we_q     <= mem_we_d;
         offset_q     <= offset_d;
         width_q      <= width_d;
         resp_rdata_q <= resp_rdata_d;
         resp_mis_q   <= resp_mis_d;
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench driving core requests and a scripted memory responder
module tb_load_store_unit;
   import memory_access_width::*;

   typedef struct {
      logic        mis;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   load_store_unit_if bus();
   load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one access: gd = ADDR cycles before grant, rd = cycles from grant to rvalid, rr = RESP cycles before ready
   task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input memory_access_width_t w, input logic [31:0] mrd,
                            input int gd, input int rd, input int rr);
      logic        mis;
      logic [3:0]  ebe;
      logic [31:0] ewd, erd;
      exp_t        e;
      int          off;
      off = int'(addr[1:0]);
      case (w)
         BYTE: begin mis = 1'b0; ebe = 4'(1 << off); ewd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; erd = {24'h0, mrd[8*off +: 8]}; end
         HALF: begin mis = addr[0]; ebe = 4'(3 << off); ewd = {wd[15:0], wd[15:0]}; erd = {16'h0, mrd[8*(off & 2) +: 16]}; end
         default: begin mis = addr[1:0] != 2'b00; ebe = 4'hF; ewd = wd; erd = mrd; end
      endcase
      e.mis   = mis;
      e.rdata = (mis || wr) ? 32'h0 : erd;
      sb.push_back(e);
      @(negedge clk);
      chk("req_ready_idle", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wd; bus.req_width = w;
      bus.mem_rdata = mrd;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.req_wdata = 32'hFFFF_FFFF; bus.req_addr = 32'hFFFF_FFFF;
      if (mis) chk("no_mem_req", bus.mem_req, 1'b0);
      else begin
         for (int i = 0; i <= gd; i++) begin
            chk("addr_req", bus.mem_req, 1'b1);
            chk("addr_addr", bus.mem_addr, {addr[31:2], 2'b00});
            chk("addr_be", bus.mem_be, ebe);
            chk("addr_we", bus.mem_we, wr);
            chk("addr_wdata", bus.mem_wdata, ewd);
            chk("addr_ready", bus.req_ready, 1'b0);
            bus.mem_gnt    = i == gd;
            bus.mem_rvalid = i < gd ? 1'b1 : rd == 0;
            @(negedge clk);
         end
         bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
         for (int i = 1; i <= rd; i++) begin
            chk("data_req", bus.mem_req, 1'b0);
            chk("data_resp", bus.resp_valid, 1'b0);
            chk("data_ready", bus.req_ready, 1'b0);
            bus.mem_rvalid = i == rd;
            @(negedge clk);
         end
         bus.mem_rvalid = 1'b0;
      end
      bus.mem_rdata = 32'h5A5A_5A5A;
      for (int i = 0; i <= rr; i++) begin
         chk("resp_valid", bus.resp_valid, 1'b1);
         chk("resp_ready_lo", bus.req_ready, 1'b0);
         if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 1);
         else if (i < rr) begin
            chk("resp_hold_rdata", bus.resp_rdata, sb[0].rdata);
            chk("resp_hold_mis", bus.resp_misaligned, sb[0].mis);
         end else begin
            e = sb.pop_front();
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_mis", bus.resp_misaligned, e.mis);
         end
         bus.resp_ready = i == rr;
         @(negedge clk);
      end
      bus.resp_ready = 1'b0;
      chk("back_idle_valid", bus.resp_valid, 1'b0);
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      bus.req_width = BYTE; bus.resp_ready = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      bus.mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_be", bus.mem_be, 4'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_resp_valid", bus.resp_valid, 1'b0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst_resp_mis", bus.resp_misaligned, 1'b0);
      chk("rst_req_ready", bus.req_ready, 1'b0);
      rst_n = 1'b1;
      #1 chk("rel_ready_before_edge", bus.req_ready, 1'b0);
      @(negedge clk);
      chk("rel_ready_after_edge", bus.req_ready, 1'b1);

      do_access(1'b0, 32'h0000_1003, 32'h0, BYTE, 32'hAABB_CCDD, 0, 0, 0);
      do_access(1'b1, 32'h0000_2002, 32'h0000_1234, HALF, 32'hDEAD_BEEF, 0, 1, 0);
      do_access(1'b0, 32'h0000_3001, 32'h0, WORD, 32'h1111_1111, 0, 0, 0);
      do_access(1'b0, 32'h0000_4002, 32'h0, HALF, 32'h1122_3344, 3, 2, 2);
      do_access(1'b0, 32'h0000_5000, 32'h0, WORD, 32'hCAFE_F00D, 1, 0, 1);
      do_access(1'b0, 32'h0000_6001, 32'h0, HALF, 32'h2222_2222, 0, 0, 0);
      do_access(1'b1, 32'h0000_7001, 32'h0000_00A5, BYTE, 32'h3333_3333, 2, 1, 0);
      do_access(1'b0, 32'h0000_8001, 32'h0, BYTE, 32'h8899_AABB, 0, 3, 1);

      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFEED_FACE;
      repeat (2) @(negedge clk);
      bus.mem_rvalid = 1'b0;
      chk("stray_idle_valid", bus.resp_valid, 1'b0);
      chk("stray_idle_ready", bus.req_ready, 1'b1);
      chk("stray_idle_req", bus.mem_req, 1'b0);

      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_9000; bus.req_width = WORD;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      chk("mid_data_req", bus.mem_req, 1'b0);
      chk("mid_data_valid", bus.resp_valid, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_valid", bus.resp_valid, 1'b0);
      chk("mid_rst_ready", bus.req_ready, 1'b0);
      chk("mid_rst_be", bus.mem_be, 4'h0);
      chk("mid_rst_addr", bus.mem_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      chk("post_rst_valid", bus.resp_valid, 1'b0);
      chk("post_rst_ready", bus.req_ready, 1'b1);
      chk("post_rst_rdata", bus.resp_rdata, 32'h0);

      do_access(1'b0, 32'h0000_A002, 32'h0, HALF, 32'hBEEF_0000, 0, 0, 0);
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 req_valid  in  1  core access request present.
REQ-004 req_ready  out  1  unit accepts a request this cycle.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_wdata  in  32  store data, right-aligned.
REQ-008 req_width  in  memory_access_width_t  BYTE/HALF/WORD.
REQ-009 resp_valid  out  1  response available.
REQ-010 resp_ready  in  1  consumer takes response.
REQ-011 resp_rdata  out  32  load data, right-aligned and unextended; feeds memory_extension data_rd.
REQ-012 resp_misaligned  out  1  access faulted on alignment; qualified by resp_valid.
REQ-013 mem_req  out  1  memory request.
REQ-014 mem_gnt  in  1  memory accepts the request.
REQ-015 mem_addr  out  32  word-aligned address, bits [1:0] = 0.
REQ-016 mem_we  out  1  write enable.
REQ-017 mem_be  out  4  byte enables.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_rvalid  in  1  read data or write acknowledge, one per granted request.
REQ-020 mem_rdata  in  32  raw memory word.

Function
REQ-021 The unit SHALL allow one outstanding access, with FSM states IDLE, ADDR, DATA, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid && req_ready, and the unit registers addr, width, write and wdata.
REQ-023 A request is misaligned if HALF has addr[0]=1 or WORD has addr[1:0]!=0; acceptance of a misaligned request SHALL go IDLE->RESP with resp_misaligned=1, resp_rdata=0 and no mem_req.
REQ-024 An aligned request SHALL go IDLE->ADDR; in ADDR mem_req=1 with registered mem_addr/mem_we/mem_be/mem_wdata held stable until mem_gnt.
REQ-025 In ADDR, mem_gnt SHALL go to DATA; mem_gnt with mem_rvalid in the same cycle SHALL go directly to RESP and capture data.
REQ-026 In DATA, mem_rvalid SHALL go to RESP and capture resp_rdata = mem_rdata >> (8*addr[1:0]), masked to 8/16/32 bits by width; stores SHALL capture 0.
REQ-027 mem_rvalid SHALL be ignored in IDLE and RESP, and in ADDR without mem_gnt.
REQ-028 In RESP, resp_valid SHALL be 1 with resp_rdata/resp_misaligned stable; resp_ready SHALL return to IDLE, and a new request is accepted at the earliest on the next cycle.
REQ-029 mem_be SHALL be: BYTE 4'b0001<<addr[1:0]; HALF 4'b0011<<addr[1:0]; WORD 4'b1111.
REQ-030 mem_wdata SHALL be: BYTE {4{wdata[7:0]}}; HALF {2{wdata[15:0]}}; WORD wdata.
REQ-031 Minimum aligned latency SHALL be 2 cycles from acceptance to resp_valid (mem_gnt and mem_rvalid in the first ADDR cycle).

Reset
REQ-032 Assertion of rst_n=0 SHALL immediately force IDLE, and all outputs SHALL be: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_misaligned=0, req_ready=0.
REQ-033 req_ready SHALL become 1 on the first clk edge after deassertion.
REQ-034 Reset mid-access SHALL abandon the access, and a later stray mem_rvalid SHALL be ignored per REQ-027.

Structure
REQ-035 memory_access_width_t SHALL remain in the memory_access_width package, and lsu_state_t (IDLE/ADDR/DATA/RESP) SHALL be added to a shared lsu package.
REQ-036 Word width SHALL use the constants.svh WORD_MASK.
REQ-037 Combinational lane logic (be, wdata replication, rdata shift/mask, misalign detect) SHALL live in one sub-module, lsu_lane_align.

Verification
REQ-038 Load BYTE addr 0x1003, mem_rdata 0xAABBCCDD, gnt and rvalid immediate -> mem_addr 0x1000, mem_be 1000, resp_rdata 0x000000AA after 2 cycles.
REQ-039 Store HALF addr 0x2002, wdata 0x1234 -> mem_we=1, mem_be 1100, mem_wdata 0x12341234, resp_valid after rvalid, resp_rdata 0.
REQ-040 Load WORD addr 0x3001 -> no mem_req, resp_valid next cycle with resp_misaligned=1.
REQ-041 mem_gnt delayed 3 cycles, rvalid 2 later, resp_ready low 2 cycles -> mem outputs stable in ADDR, resp stable in RESP, req_ready=0 throughout.
REQ-042 rst_n pulsed low in DATA, then mem_rvalid=1 -> resp_valid stays 0, req_ready=1 after deassertion.
REQ-043 Stray mem_rvalid in IDLE -> no state change, resp_valid 0.
